// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 serial byte receiver.
//  - FSM state encodings (plain 2-bit constants, legacy-compatible)
//  - Frame geometry and default bit timing (10 MHz clock, 115200 baud)
package uart_rx_byte_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_CLKS_PER_BIT = 87;
   localparam int unsigned UART_BIT_IDX_W    = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receive-side handshake bundle between the byte receiver and its consumer.
//  master (receiver): drives rx_data, rx_valid, rx_overrun, frame_err, busy; reads rx_ack
//  slave  (consumer): reads the above; drives rx_ack
interface uart_rx_byte_if;
   import uart_rx_byte_pkg::*;

   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      rx_ack;
   logic                      rx_overrun;
   logic                      frame_err;
   logic                      busy;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_overrun,
      output frame_err,
      output busy,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_overrun,
      input  frame_err,
      input  busy,
      output rx_ack
   );

endinterface

// File: rtl/uart_rx_byte_sync_ff.sv
// N-stage synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high serial line never looks like a start edge out of reset.
//  clk   in  clock
//  rst_n in  asynchronous active-low reset
//  d     in  asynchronous input
//  q     out synchronized output (last stage)
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= '1;
      end else begin
         ff_q <= {ff_q[STAGES-2:0], d};
      end
   end

   assign q = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with valid/ack output handshake.
// Oversamples the rx line with a free-running per-bit counter, samples each bit at its
// midpoint, and reports framing errors and dropped bytes.
//  clk   in  clock
//  rst_n in  asynchronous active-low reset; discards any partial frame
//  rx    in  raw serial line, idle high
//  bus   uart_rx_byte_if.master: rx_data/rx_valid/rx_ack handshake plus
//        rx_overrun (sticky), frame_err (1-cycle pulse), busy (FSM not idle)
module uart_rx_byte
   import uart_rx_byte_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rx,
   uart_rx_byte_if.master bus
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [UART_BIT_IDX_W-1:0] IDX_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   logic rx_s;
   logic rx_s_prev_q;
   logic fall;

   logic [1:0]                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [UART_BIT_IDX_W-1:0] idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;

   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      ovr_q, ovr_d;
   logic                      fe_q, fe_d;

   logic cnt_last;
   logic stop_ok;
   logic stop_bad;
   logic ack_take;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   // Edge, not level: a line stuck low after a frame cannot restart the FSM.
   assign fall     = rx_s_prev_q & ~rx_s;
   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_MID) begin
               // Still low at mid start bit: genuine start; otherwise treat as a glitch.
               if (!rx_s) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) begin
               // LSB arrives first, so shifting right leaves it in bit 0 after the last bit.
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) begin
               state_d  = ST_IDLE;
               stop_ok  = rx_s;
               stop_bad = ~rx_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output handshake. A byte completing while the consumer acks in the same cycle
   // replaces the old one without counting as an overrun.
   always_comb begin
      ack_take = valid_q & bus.rx_ack;
      data_d   = data_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      fe_d     = stop_bad;

      if (ack_take) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (stop_ok) begin
         if (!valid_q || bus.rx_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;  // set wins over a clearing ack
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s_prev_q <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
         fe_q        <= 1'b0;
      end else begin
         rx_s_prev_q <= rx_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ovr_q       <= ovr_d;
         fe_q        <= fe_d;
      end
   end

   assign bus.rx_data    = data_q;
   assign bus.rx_valid   = valid_q;
   assign bus.rx_overrun = ovr_q;
   assign bus.frame_err  = fe_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 8 clocks per bit.
// Frames are driven bit by bit on rx; expected bytes go into a scoreboard queue and are
// compared whenever the receiver presents a new byte.
module tb_uart_rx_byte;
   import uart_rx_byte_pkg::*;

   localparam int unsigned CPB = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;

   uart_rx_byte_if bus ();

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       push;
      logic       ack_after;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
      int         exp_fe;
   } vec_t;

   vec_t       vecs[6];
   int         n_vec = 0;
   int         n_err = 0;
   int         fe_pulses = 0;
   logic [7:0] exp_q[$];
   logic       mon_prev_valid;
   logic [7:0] mon_prev_data;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ack();
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
   endtask

   // Start bit, 8 data bits LSB first, stop bit. With ack_at_stop, rx_ack is high during
   // the stop-bit sample cycle only.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic hold_low,
                             input logic ack_at_stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB - 2);
      if (ack_at_stop) bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      tick(1);
      if (!hold_low) rx = 1'b1;
   endtask

   // Scoreboard monitor and frame_err pulse counter.
   initial begin
      logic [7:0] exp_b;
      mon_prev_valid = 1'b0;
      mon_prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_prev_valid = 1'b0;
            mon_prev_data  = '0;
         end else begin
            if (bus.rx_valid && (!mon_prev_valid || bus.rx_data != mon_prev_data)) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_byte: got 0x%0h, want none", bus.rx_data);
               end else begin
                  exp_b = exp_q.pop_front();
                  check("scoreboard_byte", int'(bus.rx_data), int'(exp_b));
               end
            end
            if (bus.frame_err) fe_pulses++;
            mon_prev_valid = bus.rx_valid;
            mon_prev_data  = bus.rx_data;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int fe0;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 0};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 0};
      vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 0};

      bus.rx_ack = 1'b0;
      tick(3);
      check("reset_data", int'(bus.rx_data), 0);
      check("reset_valid", int'(bus.rx_valid), 0);
      check("reset_overrun", int'(bus.rx_overrun), 0);
      check("reset_frame_err", int'(bus.frame_err), 0);
      check("reset_busy", int'(bus.busy), 0);
      rst_n = 1'b1;
      tick(4);

      // Table: single frames, overrun, framing error, ack behaviour.
      for (int v = 0; v < 6; v++) begin
         fe0 = fe_pulses;
         if (vecs[v].push) exp_q.push_back(vecs[v].data);
         send_frame(vecs[v].data, vecs[v].stop, 1'b0, 1'b0);
         check($sformatf("v%0d_valid", v), int'(bus.rx_valid), int'(vecs[v].exp_valid));
         check($sformatf("v%0d_data", v), int'(bus.rx_data), int'(vecs[v].exp_data));
         check($sformatf("v%0d_overrun", v), int'(bus.rx_overrun), int'(vecs[v].exp_ovr));
         check($sformatf("v%0d_fe_pulses", v), fe_pulses - fe0, vecs[v].exp_fe);
         check($sformatf("v%0d_busy", v), int'(bus.busy), 0);
         if (vecs[v].ack_after) begin
            pulse_ack();
            check($sformatf("v%0d_ack_valid", v), int'(bus.rx_valid), 0);
            check($sformatf("v%0d_ack_overrun", v), int'(bus.rx_overrun), 0);
         end
         tick(3);
      end

      // Bad stop bit then line held low: one error pulse, no new frame.
      fe0 = fe_pulses;
      send_frame(8'h55, 1'b0, 1'b1, 1'b0);
      tick(40);
      check("hold_low_fe_pulses", fe_pulses - fe0, 1);
      check("hold_low_busy", int'(bus.busy), 0);
      check("hold_low_valid", int'(bus.rx_valid), 0);
      check("hold_low_data", int'(bus.rx_data), 'hC3);
      rx = 1'b1;
      tick(20);
      check("hold_low_release_busy", int'(bus.busy), 0);

      // Two-cycle low glitch: START entered, then abandoned.
      fe0 = fe_pulses;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(2);
      check("glitch_busy_start", int'(bus.busy), 1);
      tick(8);
      check("glitch_busy_idle", int'(bus.busy), 0);
      check("glitch_valid", int'(bus.rx_valid), 0);
      check("glitch_fe_pulses", fe_pulses - fe0, 0);

      // Byte completes while the previous one is acked in the same cycle.
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, 1'b0, 1'b0);
      check("pre_ack_data", int'(bus.rx_data), 'h34);
      tick(3);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0, 1'b1);
      check("same_cycle_data", int'(bus.rx_data), 'h12);
      check("same_cycle_valid", int'(bus.rx_valid), 1);
      check("same_cycle_overrun", int'(bus.rx_overrun), 0);
      tick(3);

      // Asynchronous reset in the middle of data bit 4, with a byte still pending.
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         tick(CPB);
      end
      rx = 1'b0;
      tick(CPB / 2);
      check("mid_frame_busy", int'(bus.busy), 1);
      check("mid_frame_valid", int'(bus.rx_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_data", int'(bus.rx_data), 0);
      check("async_rst_valid", int'(bus.rx_valid), 0);
      check("async_rst_overrun", int'(bus.rx_overrun), 0);
      check("async_rst_frame_err", int'(bus.frame_err), 0);
      check("async_rst_busy", int'(bus.busy), 0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      check("post_rst_valid", int'(bus.rx_valid), 1);
      check("post_rst_data", int'(bus.rx_data), 'h81);
      check("post_rst_overrun", int'(bus.rx_overrun), 0);
      pulse_ack();
      tick(4);

      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
